// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces N active-low push-buttons.
// Each key runs an independent IDLE/PRESS_DB/PRESSED/REL_DB machine and
// reports a clean level plus one-cycle press, release and long-press pulses.
//
// Ports:
//   clk           board clock (50 MHz)
//   rst           synchronous active-high reset
//   key_n         raw key pins, active-low, asynchronous to clk
//   key_level     debounced pressed state (1 = pressed)
//   press_pulse   one-cycle pulse when a press is accepted
//   release_pulse one-cycle pulse when a release is accepted
//   long_pulse    one-cycle pulse once a press has been held LONG_CYCLES
module key_debounce #(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned LCNT_W = $clog2(LONG_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } state_e;

    // Two-flop synchroniser; resets to the released level
    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [N_KEYS-1:0] sync_c;

    state_e            state_q [N_KEYS];
    state_e            state_d [N_KEYS];
    logic [DCNT_W-1:0] dcnt_q  [N_KEYS];
    logic [DCNT_W-1:0] dcnt_d  [N_KEYS];
    logic [LCNT_W-1:0] lcnt_q  [N_KEYS];
    logic [LCNT_W-1:0] lcnt_d  [N_KEYS];
    logic [N_KEYS-1:0] long_done_q, long_done_d;

    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] rel_q,   rel_d;
    logic [N_KEYS-1:0] long_q,  long_d;

    // Synchroniser next-state and the pressed view of the second stage
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        sync_c  = ~sync2_q;
    end

    // Per-key next-state and output logic
    always_comb begin
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = '0;
        rel_d       = '0;
        long_d      = '0;
        for (int unsigned k = 0; k < N_KEYS; k++) begin
            state_d[k] = state_q[k];
            dcnt_d[k]  = dcnt_q[k];
            lcnt_d[k]  = lcnt_q[k];
            unique case (state_q[k])
                IDLE: begin
                    if (sync_c[k]) begin
                        state_d[k] = PRESS_DB;
                        dcnt_d[k]  = '0;
                    end
                end
                PRESS_DB: begin
                    if (!sync_c[k]) begin
                        state_d[k] = IDLE;
                        dcnt_d[k]  = '0;
                    end else if (dcnt_q[k] == DCNT_LAST) begin
                        state_d[k]     = PRESSED;
                        level_d[k]     = 1'b1;
                        press_d[k]     = 1'b1;
                        lcnt_d[k]      = '0;
                        long_done_d[k] = 1'b0;
                    end else begin
                        dcnt_d[k] = dcnt_q[k] + DCNT_W'(1);
                    end
                end
                PRESSED: begin
                    // lcnt is frozen while releasing and saturates via long_done
                    if (!sync_c[k]) begin
                        state_d[k] = REL_DB;
                        dcnt_d[k]  = '0;
                    end else if (!long_done_q[k] && lcnt_q[k] == LCNT_LAST) begin
                        long_d[k]      = 1'b1;
                        long_done_d[k] = 1'b1;
                    end else if (!long_done_q[k]) begin
                        lcnt_d[k] = lcnt_q[k] + LCNT_W'(1);
                    end
                end
                REL_DB: begin
                    // A release glitch resumes the held press without re-arming long
                    if (sync_c[k]) begin
                        state_d[k] = PRESSED;
                        dcnt_d[k]  = '0;
                    end else if (dcnt_q[k] == DCNT_LAST) begin
                        state_d[k] = IDLE;
                        level_d[k] = 1'b0;
                        rel_d[k]   = 1'b1;
                    end else begin
                        dcnt_d[k] = dcnt_q[k] + DCNT_W'(1);
                    end
                end
                default: begin
                    state_d[k] = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            long_done_q <= '0;
            level_q     <= '0;
            press_q     <= '0;
            rel_q       <= '0;
            long_q      <= '0;
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                state_q[k] <= IDLE;
                dcnt_q[k]  <= '0;
                lcnt_q[k]  <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            long_q      <= long_d;
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                state_q[k] <= state_d[k];
                dcnt_q[k]  <= dcnt_d[k];
                lcnt_q[k]  <= lcnt_d[k];
            end
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_pulse    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEBOUNCE_CYCLES=8, LONG_CYCLES=40.
// The driver pushes expected pulse events (edge number, pulse vectors,
// resulting level); a negedge monitor pops and compares them.
module tb_key_debounce;

    localparam int unsigned NK = 4;

    logic          clk;
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] long_pulse;

    key_debounce #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (40)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_n         (key_n),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    typedef struct packed {
        int unsigned   at;
        logic [NK-1:0] prs;
        logic [NK-1:0] rel;
        logic [NK-1:0] lng;
        logic [NK-1:0] lvl;
    } ev_t;

    ev_t         q[$];
    int unsigned cyc       = 0;
    logic        rst_seen  = 1'b1;
    logic        done      = 1'b0;
    int          checks    = 0;
    int          failures  = 0;
    logic [NK-1:0] lvl_exp = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter and reset capture
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic push(input int unsigned at, input logic [NK-1:0] p,
                        input logic [NK-1:0] r, input logic [NK-1:0] l,
                        input logic [NK-1:0] lv);
        ev_t e;
        e.at  = at;
        e.prs = p;
        e.rel = r;
        e.lng = l;
        e.lvl = lv;
        q.push_back(e);
    endtask

    task automatic wait_to(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: compares DUT outputs against the expected event queue
    always @(negedge clk) begin
        ev_t e;
        if (rst_seen) begin
            lvl_exp = '0;
            checks++;
            if ((key_level | press_pulse | release_pulse | long_pulse) != '0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got lvl=%b p=%b r=%b l=%b want all 0",
                         cyc, key_level, press_pulse, release_pulse, long_pulse);
            end
        end
        while (q.size() > 0 && q[0].at < cyc) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_event at=%0d got none want p=%b r=%b l=%b",
                     e.at, e.prs, e.rel, e.lng);
        end
        if (q.size() > 0 && q[0].at == cyc) begin
            e = q.pop_front();
            lvl_exp = e.lvl;
            checks++;
            if (press_pulse !== e.prs || release_pulse !== e.rel || long_pulse !== e.lng) begin
                failures++;
                $display("FAIL pulse_event cyc=%0d got p=%b r=%b l=%b want p=%b r=%b l=%b",
                         cyc, press_pulse, release_pulse, long_pulse, e.prs, e.rel, e.lng);
            end
        end else if ((press_pulse | release_pulse | long_pulse) != '0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse cyc=%0d got p=%b r=%b l=%b want none",
                     cyc, press_pulse, release_pulse, long_pulse);
        end
        checks++;
        if (key_level !== lvl_exp) begin
            failures++;
            $display("FAIL key_level cyc=%0d got %b want %b", cyc, key_level, lvl_exp);
        end
        if (done) begin
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL pending_event at=%0d got none want p=%b r=%b l=%b",
                         e.at, e.prs, e.rel, e.lng);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // Directed stimulus
    initial begin
        int unsigned c;
        rst   = 1'b1;
        key_n = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Clean press on key 0, long press, release glitch, then release
        c = cyc;
        key_n[0] = 1'b0;
        push(c + 11, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        push(c + 51, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        wait_to(c + 60);
        key_n[0] = 1'b1;
        wait_to(c + 64);
        key_n[0] = 1'b0;
        wait_to(c + 100);
        key_n[0] = 1'b1;
        push(c + 111, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_to(c + 125);

        // Bounce on key 1: toggles every 3 cycles, never stable long enough
        for (int i = 0; i < 10; i++) begin
            key_n[1] = ~key_n[1];
            repeat (3) @(negedge clk);
        end
        repeat (20) @(negedge clk);

        // All keys pressed together, long press together, released together
        c = cyc;
        key_n = 4'b0000;
        push(c + 11, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        push(c + 51, 4'b0000, 4'b0000, 4'b1111, 4'b1111);
        wait_to(c + 60);
        key_n = 4'b1111;
        push(c + 71, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        wait_to(c + 85);

        // Key 3 held, key 2 mid-debounce, reset applied at edge c+26
        c = cyc;
        key_n[3] = 1'b0;
        push(c + 11, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
        wait_to(c + 20);
        key_n[2] = 1'b0;
        wait_to(c + 25);
        rst = 1'b1;
        wait_to(c + 26);
        rst = 1'b0;
        push(c + 37, 4'b1100, 4'b0000, 4'b0000, 4'b1100);
        wait_to(c + 45);
        key_n = 4'b1111;
        push(c + 56, 4'b0000, 4'b1100, 4'b0000, 4'b0000);
        wait_to(c + 75);

        done = 1'b1;
        repeat (5) @(negedge clk);
        $display("FAIL end_of_run monitor did not finish got running want finished");
        $fatal(1, "monitor did not finish");
    end

endmodule
